// File: rtl/iotdf_stream_tx.sv
// iotdf_stream_tx: buffers 128-bit sample words and streams them MSB-byte-first to the IoT filter engine.
// Revision 1.0 - initial release
`default_nettype none

module iotdf_stream_tx #(
  parameter int FIFO_DEPTH      = 4,
  parameter int WORDS_PER_ROUND = 8,
  parameter int ROUND_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [127:0]       wr_data,
  output logic               full,
  output logic               overflow,
  input  logic               start,
  input  logic [2:0]         cfg_fn,
  input  logic [ROUND_W-1:0] cfg_rounds,
  input  logic               busy,
  output logic               in_en,
  output logic [7:0]         iot_in,
  output logic [2:0]         fn_sel,
  output logic               active,
  output logic               done
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int WCW = (WORDS_PER_ROUND > 1) ? $clog2(WORDS_PER_ROUND) : 1;

  localparam logic [AW:0]      C_DEPTH  = (AW+1)'(FIFO_DEPTH);
  localparam logic [WCW-1:0]   C_WLAST  = WCW'(WORDS_PER_ROUND - 1);
  localparam logic [ROUND_W-1:0] C_ONE_ROUND = ROUND_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [127:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;

  logic [1:0]         state_q, state_d;
  logic [127:0]       shift_q, shift_d;
  logic [3:0]         byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [2:0]         fn_q, fn_d;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty = (count_q == '0);
  assign full    = (count_q == C_DEPTH);
  assign w_push  = wr_en & ~full;
  assign w_pop   = (state_q == S_LOAD) & ~w_empty;

  // A write while full is lost even if a pop frees a slot on the same edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full);
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign in_en  = (state_q == S_SEND) & ~busy;
  assign iot_in = shift_q[127:120];
  assign fn_sel = fn_q;
  assign active = (state_q == S_LOAD) | (state_q == S_SEND);
  assign done   = (state_q == S_DONE);
  assign overflow = overflow_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    rounds_d   = rounds_q;
    fn_d       = fn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fn_d       = cfg_fn;
          rounds_d   = cfg_rounds;
          word_cnt_d = '0;
          state_d    = (cfg_rounds == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (!w_empty) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_cnt_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!busy) begin
          shift_d    = {shift_q[119:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'hF) begin
            state_d = S_LOAD;
            // Round boundary: the last word of a round may end the session.
            if (word_cnt_q == C_WLAST) begin
              word_cnt_d = '0;
              if (rounds_q != '0) begin
                rounds_d = rounds_q - 1'b1;
              end
              if (rounds_q <= C_ONE_ROUND) begin
                state_d = S_DONE;
              end
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      rounds_q   <= '0;
      fn_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      rounds_q   <= rounds_d;
      fn_q       <= fn_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iotdf_stream_tx.sv
// tb_iotdf_stream_tx: directed self-checking bench for iotdf_stream_tx.
// Revision 1.0 - initial release
`default_nettype none

module tb_iotdf_stream_tx;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [127:0] wr_data;
  logic         full;
  logic         overflow;
  logic         start;
  logic [2:0]   cfg_fn;
  logic [7:0]   cfg_rounds;
  logic         busy;
  logic         in_en;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic         active;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;
  int nbytes  = 0;
  int ndone   = 0;
  logic [7:0] byte_q [$];

  iotdf_stream_tx #(
    .FIFO_DEPTH      (4),
    .WORDS_PER_ROUND (8),
    .ROUND_W         (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .overflow   (overflow),
    .start      (start),
    .cfg_fn     (cfg_fn),
    .cfg_rounds (cfg_rounds),
    .busy       (busy),
    .in_en      (in_en),
    .iot_in     (iot_in),
    .fn_sel     (fn_sel),
    .active     (active),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && in_en) begin
      byte_q.push_back(iot_in);
      nbytes++;
    end
    if (rst && done) begin
      ndone++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_word(input int k);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      w[127-8*j -: 8] = 8'(16*k + j);
    end
    return w;
  endfunction

  task automatic write_word(input int k);
    int n;
    n = 0;
    while (full && n < 200) begin
      tick();
      n++;
    end
    if (full) check("write_timeout", 1'b1, 1'b0);
    wr_en   = 1'b1;
    wr_data = mk_word(k);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] fn, input logic [7:0] rounds);
    start      = 1'b1;
    cfg_fn     = fn;
    cfg_rounds = rounds;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_byte(input logic [7:0] v);
    int n;
    n = 0;
    #1;
    while (!(in_en && iot_in == v) && n < 500) begin
      tick();
      n++;
    end
    if (!(in_en && iot_in == v)) check("wait_byte_timeout", iot_in, v);
  endtask

  task automatic wait_nbytes(input int target);
    int n;
    n = 0;
    while (nbytes < target && n < 1000) begin
      tick();
      n++;
    end
    if (nbytes < target) check("wait_nbytes_timeout", nbytes, target);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_order(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < byte_q.size(); i++) begin
      if (byte_q[i] !== 8'(i)) bad++;
    end
    check(tag, bad, 0);
  endtask

  task automatic clear_mon();
    byte_q.delete();
    nbytes = 0;
    ndone  = 0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    cfg_fn = '0; cfg_rounds = '0; busy = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_full", full, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_in_en", in_en, 1'b0);
    check("rst_iot_in", iot_in, 8'h00);
    check("rst_fn_sel", fn_sel, 3'd0);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b1;
    tick();

    // Session 1: one round of 8 words, no busy
    write_word(0);
    pulse_start(3'd1, 8'd1);
    check("s1_fn_sel", fn_sel, 3'd1);
    check("s1_active", active, 1'b1);
    for (int k = 1; k < 8; k++) write_word(k);
    check("s1_fn_hold", fn_sel, 3'd1);
    wait_done();
    check("s1_bytes_at_done", nbytes, 128);
    tick();
    check("s1_done_once", ndone, 1);
    check("s1_done_low", done, 1'b0);
    check("s1_active_end", active, 1'b0);
    check("s1_fn_kept", fn_sel, 3'd1);
    check_order("s1_order");
    check("s1_first_bytes", {byte_q[0], byte_q[1], byte_q[15]}, 24'h00010F);

    // Session 2: busy held for 3 cycles on byte 15 of word 0
    clear_mon();
    for (int k = 0; k < 4; k++) write_word(k);
    pulse_start(3'd2, 8'd1);
    wait_byte(8'h0F);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s2_busy_in_en", in_en, 1'b0);
      check("s2_busy_iot_in", iot_in, 8'h0F);
      tick();
    end
    busy = 1'b0;
    check("s2_bytes_before_release", nbytes, 15);
    for (int k = 4; k < 8; k++) write_word(k);
    wait_done();
    check("s2_bytes", nbytes, 128);
    check_order("s2_order");
    tick();

    // Session 3: overflow, then starvation in the middle of a round
    clear_mon();
    for (int k = 0; k < 5; k++) begin
      wr_en   = 1'b1;
      wr_data = mk_word(k);
      tick();
      if (k == 3) begin
        check("s3_full_after4", full, 1'b1);
        check("s3_no_ovf_yet", overflow, 1'b0);
      end
    end
    wr_en = 1'b0;
    check("s3_overflow_set", overflow, 1'b1);
    check("s3_full_still", full, 1'b1);
    pulse_start(3'd3, 8'd1);
    wait_nbytes(64);
    repeat (5) tick();
    check("s3_starve_active", active, 1'b1);
    check("s3_starve_in_en", in_en, 1'b0);
    check("s3_starve_nbytes", nbytes, 64);
    repeat (15) tick();
    check("s3_starve_in_en2", in_en, 1'b0);
    check("s3_overflow_sticky", overflow, 1'b1);
    check_order("s3_order_4words");
    write_word(4);
    wait_nbytes(80);
    for (int k = 5; k < 8; k++) write_word(k);
    wait_done();
    check("s3_bytes", nbytes, 128);
    check_order("s3_order");
    tick();

    // Session 4: zero rounds, ignored start, reset mid-word
    clear_mon();
    for (int k = 0; k < 4; k++) write_word(k);
    check("s4_full", full, 1'b1);
    pulse_start(3'd5, 8'd0);
    check("s4_done_zero", done, 1'b1);
    check("s4_fn_zero", fn_sel, 3'd5);
    check("s4_active_zero", active, 1'b0);
    check("s4_fifo_untouched", full, 1'b1);
    tick();
    check("s4_done_drop", done, 1'b0);
    check("s4_no_bytes", nbytes, 0);
    pulse_start(3'd6, 8'd1);
    wait_byte(8'h00);
    pulse_start(3'd7, 8'd0);
    check("s4_ignored_fn", fn_sel, 3'd6);
    check("s4_ignored_active", active, 1'b1);
    write_word(4);
    check("s4_full_again", full, 1'b1);
    wait_byte(8'h06);
    rst = 1'b0;
    #1;
    check("s4_rst_in_en", in_en, 1'b0);
    check("s4_rst_iot_in", iot_in, 8'h00);
    check("s4_rst_active", active, 1'b0);
    check("s4_rst_full", full, 1'b0);
    check("s4_rst_overflow", overflow, 1'b0);
    check("s4_rst_fn_sel", fn_sel, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    check("s4_post_active", active, 1'b0);
    check("s4_post_full", full, 1'b0);
    check("s4_bytes_before_rst", nbytes, 6);
    check_order("s4_order");
    pulse_start(3'd1, 8'd1);
    repeat (5) tick();
    check("s4_empty_active", active, 1'b1);
    check("s4_empty_in_en", in_en, 1'b0);
    check("s4_empty_nbytes", nbytes, 6);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iotdf_stream_tx.md
Name: iotdf_stream_tx

Overview:
- Transmit-side driver for the IoT data-filter engine's byte-stream input.
- Buffers 128-bit sample words from a host-side writer and serializes each word into 16 bytes on iot_in, qualified by in_en and throttled by the engine's busy.
- Holds fn_sel stable for a whole session.
- Sends cfg_rounds rounds of WORDS_PER_ROUND words, then pulses done.

Parameters:
- FIFO_DEPTH, 4, number of 128-bit words buffered (power of two, >= 2)
- WORDS_PER_ROUND, 8, words per engine round
- ROUND_W, 8, width of the round-count configuration

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- wr_en  input  1  host write strobe for wr_data
- wr_data  input  128  sample word; bits [127:120] are transmitted first
- full  output  1  FIFO holds FIFO_DEPTH words
- overflow  output  1  sticky: a write arrived while full
- start  input  1  one-cycle session start pulse
- cfg_fn  input  3  function select latched on start
- cfg_rounds  input  ROUND_W  rounds to send in this session
- busy  input  1  engine busy (combinational from engine)
- in_en  output  1  byte-valid strobe to engine
- iot_in  output  8  byte to engine
- fn_sel  output  3  latched function select
- active  output  1  session in progress
- done  output  1  one-cycle pulse at end of session

Behaviour:
- Reset values (rst=0, immediate): FIFO empty, full=0, overflow=0, in_en=0, iot_in=0, fn_sel=0, active=0, done=0, state IDLE, all counters 0. Reset mid-session aborts it; nothing resumes.
- Transfer rule: a byte moves on a rising edge with in_en=1. in_en = (state==SEND) & !busy, combinational. iot_in is driven straight from the shift-register top byte and is stable throughout SEND.
- FIFO:
  - A write is accepted iff wr_en=1 and full=0, both sampled at the edge.
  - A write arriving while full is dropped and sets overflow, which stays set until reset. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
- FSM IDLE:
  - active=0. On start: latch fn_sel<=cfg_fn and rounds_left<=cfg_rounds; word_cnt<=0.
  - If cfg_rounds==0, go to DONE. Otherwise go to LOAD.
  - start in any other state is ignored.
- FSM LOAD:
  - If the FIFO is non-empty: pop the head into shift_reg[127:0], set byte_cnt<=0, go to SEND (one cycle).
  - If the FIFO is empty: wait in LOAD with in_en=0. Gaps are legal; the engine counts only in_en cycles.
- FSM SEND:
  - Each transfer shifts shift_reg left 8 bits and increments byte_cnt.
  - While busy=1: hold, no shift.
  - On the transfer with byte_cnt==15: increment word_cnt (mod WORDS_PER_ROUND).
    - If word_cnt wraps, decrement rounds_left.
    - If rounds_left reaches 0 at that wrap, go to DONE. Otherwise go to LOAD.
- FSM DONE: done=1 for one cycle, fn_sel kept, go to IDLE.
- active = 1 in LOAD and SEND.
- Throughput: 17 cycles per word with no busy and no FIFO starvation (1 LOAD + 16 SEND).
- Byte order: word W is sent as W[127:120], W[119:112], … , W[7:0].
- Widths:
  - byte_cnt: 4 bits.
  - word_cnt: clog2(WORDS_PER_ROUND) bits.
  - rounds_left: ROUND_W bits, no wrap below 0.

Test Plan:
- Reset, write 0x000102…0F, start with cfg_fn=1, cfg_rounds=1, busy=0, remaining 7 words written back-to-back → 128 in_en pulses. First word yields iot_in 0x00,0x01,…,0x0F. fn_sel=1 throughout. done pulses exactly once after the 128th byte.
- Hold busy=1 for 3 cycles at byte 15 of word 0 → in_en=0 for those cycles, iot_in held at 0x0F, no byte lost or duplicated. Total in_en count is still 128.
- FIFO starvation: start with an empty FIFO, write one word 20 cycles later → in_en stays 0 until LOAD pops, then 16 bytes follow. active=1 throughout the wait.
- Write 5 words with FIFO_DEPTH=4 and no start → full=1 after the 4th write, 5th is dropped, overflow=1 and stays set. Subsequent start sends the 4 stored words in order.
- start with cfg_rounds=0 → done pulses 1 cycle later, in_en never asserts, FIFO contents are untouched. A second start while active (cfg_fn=7) is ignored and fn_sel is unchanged.
- Assert rst=0 mid-word (byte 6) → in_en, iot_in, active, full and overflow go to 0 immediately. After release the FSM is in IDLE and the FIFO is empty.
